// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC unit: default parameters and the
// next-PC source encoding used by the priority mux.
package pc_pkg;

  localparam int unsigned AW_DEF           = 64;
  localparam logic [63:0] RESET_VECTOR_DEF = 64'h0;
  localparam logic [63:0] TRAP_VECTOR_DEF  = 64'h100;
  localparam int unsigned STEP_DEF         = 4;
  localparam int unsigned RAS_DEPTH_DEF    = 4;

  // Next-PC source, listed in decreasing priority
  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_REDIR,
    SRC_PEND,
    SRC_RAS,
    SRC_SEQ
  } next_src_e;

endpackage

// File: rtl/return_addr_stack.sv
// Return-address stack: a circular buffer with a top pointer and an entry count.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             drop all entries (count=0); push/pop ignored that cycle
//   push, push_data   push a return address (overwrites the oldest entry when full)
//   pop               pop the top entry; on an empty stack sets underflow instead
//   top_c             current top entry (combinational read)
//   empty, full       registered occupancy flags
//   overflow          sticky: a push overwrote the oldest entry
//   underflow         sticky: a pop found the stack empty
module return_addr_stack #(
  parameter int unsigned AW        = 64,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_c,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] mem_q [RAS_DEPTH];
  logic [AW-1:0] mem_d [RAS_DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          do_pop;

  // Next-state: pop+push replaces the top in place; push on full wraps over the oldest
  always_comb begin
    mem_d  = mem_q;
    top_d  = top_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    do_pop = pop && (cnt_q != '0);
    if (flush) begin
      cnt_d = '0;
    end else begin
      if (pop && !do_pop) unf_d = 1'b1;
      if (do_pop && push) begin
        mem_d[top_q] = push_data;
      end else if (do_pop) begin
        top_d = top_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end else if (push) begin
        top_d        = top_q + PW'(1);
        mem_d[top_d] = push_data;
        if (cnt_q == CW'(RAS_DEPTH)) ovf_d = 1'b1;
        else                         cnt_d = cnt_q + CW'(1);
      end
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CW'(RAS_DEPTH));
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage needs no reset: the count gates every read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top_c     = mem_q[top_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: holds the PC, presents it over a valid/ready
// handshake, buffers redirects/traps that arrive during a stall, and picks the
// next PC from trap vector, redirect, buffered redirect, RAS prediction or step.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   fetch_valid / fetch_ready       request handshake; pc_out accepted when both high
//   pc_out                          current PC
//   redirect_valid/redirect_target  resolved branch/jump
//   trap                            exception, next PC = TRAP_VECTOR
//   call_hint / ret_hint            instruction at pc_out is a call / return
//   ras_empty/full/overflow/underflow  return-address stack status
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned   AW           = AW_DEF,
  parameter logic [AW-1:0] RESET_VECTOR = AW'(RESET_VECTOR_DEF),
  parameter logic [AW-1:0] TRAP_VECTOR  = AW'(TRAP_VECTOR_DEF),
  parameter int unsigned   STEP         = STEP_DEF,
  parameter int unsigned   RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          fetch_valid,
  input  logic          fetch_ready,
  output logic [AW-1:0] pc_out,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_target,
  input  logic          trap,
  input  logic          call_hint,
  input  logic          ret_hint,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_overflow,
  output logic          ras_underflow
);

  logic          fetch_valid_q, fetch_valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          pend_trap_q, pend_trap_d;
  logic          pend_redir_q, pend_redir_d;
  logic [AW-1:0] pend_tgt_q, pend_tgt_d;

  logic          accept_c;
  logic          trap_sel_c;
  logic [AW-1:0] seq_pc_c;
  logic [AW-1:0] ras_top_c;
  logic          ras_push_c, ras_pop_c, ras_flush_c;
  next_src_e     src_c;

  assign accept_c   = fetch_valid_q & fetch_ready;
  assign trap_sel_c = trap | pend_trap_q;
  assign seq_pc_c   = pc_q + AW'(STEP);

  // Next-PC source by strict priority
  always_comb begin
    src_c = SRC_SEQ;
    if (trap_sel_c)                   src_c = SRC_TRAP;
    else if (redirect_valid)          src_c = SRC_REDIR;
    else if (pend_redir_q)            src_c = SRC_PEND;
    else if (ret_hint && !ras_empty)  src_c = SRC_RAS;
  end

  // PC, pending buffer and RAS control
  always_comb begin
    fetch_valid_d = 1'b1;
    pc_d          = pc_q;
    pend_trap_d   = pend_trap_q;
    pend_redir_d  = pend_redir_q;
    pend_tgt_d    = pend_tgt_q;
    ras_push_c    = 1'b0;
    ras_pop_c     = 1'b0;
    ras_flush_c   = 1'b0;
    if (accept_c) begin
      case (src_c)
        SRC_TRAP:  pc_d = TRAP_VECTOR;
        SRC_REDIR: pc_d = redirect_target;
        SRC_PEND:  pc_d = pend_tgt_q;
        SRC_RAS:   pc_d = ras_top_c;
        SRC_SEQ:   pc_d = seq_pc_c;
        default:   pc_d = seq_pc_c;
      endcase
      pend_trap_d  = 1'b0;
      pend_redir_d = 1'b0;
      // A trap flushes the stack and suppresses this cycle's hints
      ras_flush_c  = trap_sel_c;
      ras_push_c   = call_hint & ~trap_sel_c;
      ras_pop_c    = ret_hint & ~trap_sel_c;
    end else if (trap) begin
      pend_trap_d  = 1'b1;
      pend_redir_d = 1'b0;
    end else if (redirect_valid && !pend_trap_q) begin
      // A pending trap outranks any later redirect, so it is dropped
      pend_redir_d = 1'b1;
      pend_tgt_d   = redirect_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      pc_q          <= RESET_VECTOR;
      pend_trap_q   <= 1'b0;
      pend_redir_q  <= 1'b0;
      pend_tgt_q    <= '0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      pc_q          <= pc_d;
      pend_trap_q   <= pend_trap_d;
      pend_redir_q  <= pend_redir_d;
      pend_tgt_q    <= pend_tgt_d;
    end
  end

  return_addr_stack #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (ras_flush_c),
    .push      (ras_push_c),
    .pop       (ras_pop_c),
    .push_data (seq_pc_c),
    .top_c     (ras_top_c),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign fetch_valid = fetch_valid_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by random stimulus,
// every cycle compared against a queue-based reference model.
module tb_pc_fetch_unit;

  localparam int unsigned AW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RSTV  = 64'h0;
  localparam logic [63:0] TRAPV = 64'h100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [AW-1:0] pc_out;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          trap;
  logic          call_hint;
  logic          ret_hint;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_overflow;
  logic          ras_underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] m_pc;
  logic        m_fv;
  logic        m_pt;
  logic        m_pr;
  logic [63:0] m_ptgt;
  logic [63:0] m_ras[$];
  logic        m_of;
  logic        m_uf;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .AW           (AW),
    .RESET_VECTOR (RSTV),
    .TRAP_VECTOR  (TRAPV),
    .STEP         (4),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .pc_out          (pc_out),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .call_hint       (call_hint),
    .ret_hint        (ret_hint),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_overflow    (ras_overflow),
    .ras_underflow   (ras_underflow)
  );

  task automatic chk(input string tag, input string fld, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "pc_out",        pc_out,             m_pc);
    chk(tag, "fetch_valid",   64'(fetch_valid),   64'(m_fv));
    chk(tag, "ras_empty",     64'(ras_empty),     64'(m_ras.size() == 0));
    chk(tag, "ras_full",      64'(ras_full),      64'(m_ras.size() == DEPTH));
    chk(tag, "ras_overflow",  64'(ras_overflow),  64'(m_of));
    chk(tag, "ras_underflow", 64'(ras_underflow), 64'(m_uf));
  endtask

  task automatic model_reset();
    m_pc   = RSTV;
    m_fv   = 1'b0;
    m_pt   = 1'b0;
    m_pr   = 1'b0;
    m_ptgt = '0;
    m_ras.delete();
    m_of   = 1'b0;
    m_uf   = 1'b0;
  endtask

  // One clock of architectural behaviour, stack kept as a queue (newest at back)
  task automatic model_step(input logic rdy, input logic rv, input logic [63:0] tg,
                            input logic tr, input logic ca, input logic re);
    logic [63:0] npc;
    if (m_fv && rdy) begin
      if (tr || m_pt) begin
        npc = TRAPV;
        m_ras.delete();
      end else begin
        if (rv)                            npc = tg;
        else if (m_pr)                     npc = m_ptgt;
        else if (re && m_ras.size() > 0)   npc = m_ras[$];
        else                               npc = m_pc + 64'd4;
        if (re) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
          else                  m_uf = 1'b1;
        end
        if (ca) begin
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_of = 1'b1;
          end
          m_ras.push_back(m_pc + 64'd4);
        end
      end
      m_pc = npc;
      m_pt = 1'b0;
      m_pr = 1'b0;
    end else if (tr) begin
      m_pt = 1'b1;
      m_pr = 1'b0;
    end else if (rv && !m_pt) begin
      m_pr   = 1'b1;
      m_ptgt = tg;
    end
    m_fv = 1'b1;
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [63:0] tg,
                      input logic tr, input logic ca, input logic re);
    fetch_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = tg;
    trap            = tr;
    call_hint       = ca;
    ret_hint        = re;
    model_step(rdy, rv, tg, tr, ca, re);
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    fetch_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap            = 1'b0;
    call_hint       = 1'b0;
    ret_hint        = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_pop[4];
    rst_n = 1'b1;
    #1;
    do_reset();

    // Sequential fetch: 0, 4, 8, 12
    repeat (4) step(1, 0, '0, 0, 0, 0);
    chk("seq", "pc_out", pc_out, 64'hC);

    // Two redirects during a stall: PC held, newest wins
    step(0, 1, 64'h40, 0, 0, 0);
    step(0, 1, 64'h80, 0, 0, 0);
    chk("stall", "pc_out", pc_out, 64'hC);
    step(1, 0, '0, 0, 0, 0);
    chk("stall_redir", "pc_out", pc_out, 64'h80);

    // Trap beats same-cycle redirect and flushes the stack
    step(1, 0, '0, 0, 1, 0);
    step(1, 1, 64'h200, 1, 0, 0);
    chk("trap", "pc_out", pc_out, TRAPV);
    chk("trap", "ras_empty", 64'(ras_empty), 64'h1);

    // Calls at 0x10 and 0x20, two returns, then an underflowing return
    step(1, 1, 64'h10, 0, 0, 0);
    step(1, 1, 64'h20, 0, 1, 0);
    step(1, 0, '0, 0, 1, 0);
    step(1, 0, '0, 0, 0, 1);
    chk("ret1", "pc_out", pc_out, 64'h24);
    step(1, 0, '0, 0, 0, 1);
    chk("ret2", "pc_out", pc_out, 64'h14);
    step(1, 0, '0, 0, 0, 1);
    chk("ret_uf", "pc_out", pc_out, 64'h18);
    chk("ret_uf", "ras_underflow", 64'(ras_underflow), 64'h1);

    // Five calls into a four-entry stack, then four pops
    do_reset();
    step(1, 0, '0, 0, 0, 0);
    repeat (5) step(1, 0, '0, 0, 1, 0);
    chk("ovf", "ras_full", 64'(ras_full), 64'h1);
    chk("ovf", "ras_overflow", 64'(ras_overflow), 64'h1);
    exp_pop[0] = 64'h14; exp_pop[1] = 64'h10; exp_pop[2] = 64'hC; exp_pop[3] = 64'h8;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, '0, 0, 0, 1);
      chk("ovf_pop", "pc_out", pc_out, exp_pop[i]);
    end
    chk("ovf_pop", "ras_empty", 64'(ras_empty), 64'h1);

    // Address wrap at the top of the space
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    chk("wrap", "pc_out", pc_out, 64'h0);

    // Reset asserted mid-stall with a redirect pending
    step(1, 0, '0, 0, 1, 0);
    step(0, 1, 64'h300, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    chk("midrst_pend", "pc_out", pc_out, 64'h4);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) do_reset();
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 6) == 0,
           {$urandom, $urandom} & ~64'h3,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
